// File: rtl/alu_test_sequencer_pkg.sv
// Shared definitions for the ALU test sequencer: cpu ALU op codes and sequencer states.
package alu_test_sequencer_pkg;

  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_LSH  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_ADDU = 4'b0110;
  localparam logic [3:0] OP_ADDC = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_SUBC = 4'b1010;
  localparam logic [3:0] OP_CMP  = 4'b1011;

  // firstFailIndex value meaning "no mismatch recorded yet"
  localparam logic [3:0] INDEX_NONE = 4'hF;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} seqState_e;

  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/alu_test_sequencer_if.sv
// CPU-facing ALU/register-address bus; the sequencer is the master, the cpu the slave.
interface alu_test_sequencer_if #(
  parameter int unsigned REG_WIDTH     = 16,
  parameter int unsigned REG_ADDR_BITS = 3
);
  logic [3:0]               aluOpCode;
  logic [REG_ADDR_BITS-1:0] regAddressA;
  logic [REG_ADDR_BITS-1:0] regAddressB;
  logic                     regWriteEnable;
  logic [REG_WIDTH-1:0]     aluResult;

  modport master (
    output aluOpCode, regAddressA, regAddressB, regWriteEnable,
    input  aluResult
  );

  modport slave (
    input  aluOpCode, regAddressA, regAddressB, regWriteEnable,
    output aluResult
  );
endinterface

// File: rtl/alu_test_vector_rom.sv
// Fixed stimulus table; registers in the cpu are assumed preloaded with rN = N.
module alu_test_vector_rom
  import alu_test_sequencer_pkg::*;
#(
  parameter int unsigned REG_WIDTH     = 16,
  parameter int unsigned REG_ADDR_BITS = 3
) (
  input  logic [3:0]               index,
  output logic [3:0]               opCode,
  output logic [REG_ADDR_BITS-1:0] addrA,
  output logic [REG_ADDR_BITS-1:0] addrB,
  output logic [REG_WIDTH-1:0]     expected
);

  logic [3:0]  op;
  logic [2:0]  a;
  logic [2:0]  b;
  logic [15:0] e;

  always_comb begin
    {op, a, b, e} = {OP_ADD, 3'd0, 3'd0, 16'd0};
    case (index)
      4'd0:  {op, a, b, e} = {OP_ADD,  3'd0, 3'd0, 16'd0};
      4'd1:  {op, a, b, e} = {OP_ADD,  3'd1, 3'd1, 16'd2};
      4'd2:  {op, a, b, e} = {OP_ADD,  3'd3, 3'd2, 16'd5};
      4'd3:  {op, a, b, e} = {OP_ADDU, 3'd1, 3'd1, 16'd2};
      4'd4:  {op, a, b, e} = {OP_SUB,  3'd1, 3'd0, 16'd1};
      4'd5:  {op, a, b, e} = {OP_SUB,  3'd3, 3'd3, 16'd0};
      4'd6:  {op, a, b, e} = {OP_SUB,  3'd2, 3'd3, 16'hFFFF};
      4'd7:  {op, a, b, e} = {OP_AND,  3'd3, 3'd3, 16'd3};
      4'd8:  {op, a, b, e} = {OP_AND,  3'd1, 3'd2, 16'd0};
      4'd9:  {op, a, b, e} = {OP_OR,   3'd1, 3'd2, 16'd3};
      4'd10: {op, a, b, e} = {OP_OR,   3'd0, 3'd0, 16'd0};
      4'd11: {op, a, b, e} = {OP_XOR,  3'd3, 3'd3, 16'd0};
      4'd12: {op, a, b, e} = {OP_XOR,  3'd1, 3'd3, 16'd2};
      4'd13: {op, a, b, e} = {OP_XOR,  3'd2, 3'd1, 16'd3};
      4'd14: {op, a, b, e} = {OP_AND,  3'd7, 3'd5, 16'd5};
      4'd15: {op, a, b, e} = {OP_OR,   3'd4, 3'd2, 16'd6};
    endcase
    opCode   = op;
    addrA    = REG_ADDR_BITS'(a);
    addrB    = REG_ADDR_BITS'(b);
    // sign-extend so the all-ones SUB result tracks REG_WIDTH
    expected = REG_WIDTH'($signed(e));
  end

endmodule

// File: rtl/alu_test_sequencer.sv
// On-board ALU stimulus/check engine: applies table vectors to the cpu, waits, compares, tallies.
module alu_test_sequencer
  import alu_test_sequencer_pkg::*;
#(
  parameter int unsigned REG_WIDTH     = 16,
  parameter int unsigned REG_ADDR_BITS = 3,
  parameter int unsigned NUM_VECTORS   = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  alu_test_sequencer_if.master        cpuBus,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [7:0]                  failCount,
  output logic [3:0]                  firstFailIndex,
  output logic [3:0]                  vectorIndex
);

  localparam logic [3:0] LAST_INDEX  = 4'(NUM_VECTORS - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  seqState_e                state;
  logic [3:0]               settleCount;
  logic [REG_WIDTH-1:0]     expectedReg;
  logic [3:0]               romIndex;
  logic [3:0]               romOp;
  logic [REG_ADDR_BITS-1:0] romA;
  logic [REG_ADDR_BITS-1:0] romB;
  logic [REG_WIDTH-1:0]     romExpected;
  logic                     mismatch;

  // The ROM looks one vector ahead so the cpu inputs are already valid during APPLY.
  always_comb begin
    romIndex = vectorIndex;
    if (state == IDLE || state == DONE) romIndex = '0;
    else if (state == CHECK)            romIndex = vectorIndex + 4'd1;
  end

  alu_test_vector_rom #(
    .REG_WIDTH    (REG_WIDTH),
    .REG_ADDR_BITS(REG_ADDR_BITS)
  ) vectorRom (
    .index   (romIndex),
    .opCode  (romOp),
    .addrA   (romA),
    .addrB   (romB),
    .expected(romExpected)
  );

  assign mismatch = (cpuBus.aluResult != expectedReg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      cpuBus.aluOpCode      <= '0;
      cpuBus.regAddressA    <= '0;
      cpuBus.regAddressB    <= '0;
      cpuBus.regWriteEnable <= 1'b0;
      vectorIndex           <= '0;
      failCount             <= '0;
      firstFailIndex        <= INDEX_NONE;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      pass                  <= 1'b0;
      settleCount           <= '0;
      expectedReg           <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state              <= APPLY;
            vectorIndex        <= '0;
            failCount          <= '0;
            firstFailIndex     <= INDEX_NONE;
            busy               <= 1'b1;
            done               <= 1'b0;
            pass               <= 1'b0;
            cpuBus.aluOpCode   <= romOp;
            cpuBus.regAddressA <= romA;
            cpuBus.regAddressB <= romB;
            expectedReg        <= romExpected;
          end
        end
        APPLY: begin
          settleCount <= SETTLE_LOAD;
          state       <= SETTLE;
        end
        SETTLE: begin
          settleCount <= settleCount - 4'd1;
          if (settleCount == 4'd1) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            failCount <= satInc8(failCount);
            if (firstFailIndex == INDEX_NONE) firstFailIndex <= vectorIndex;
          end
          if (vectorIndex == LAST_INDEX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (failCount == 8'd0) && !mismatch;
          end else begin
            state              <= APPLY;
            vectorIndex        <= vectorIndex + 4'd1;
            cpuBus.aluOpCode   <= romOp;
            cpuBus.regAddressA <= romA;
            cpuBus.regAddressB <= romB;
            expectedReg        <= romExpected;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_test_sequencer.sv
// Scoreboard bench for alu_test_sequencer with a behavioural cpu ALU model (rN = N).
module tb_alu_test_sequencer;
  import alu_test_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  int   faultMode = 0;
  int   total = 0;
  int   bad = 0;
  int   cycleCount = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount++;

  alu_test_sequencer_if #(.REG_WIDTH(16), .REG_ADDR_BITS(3)) bus0();
  alu_test_sequencer_if #(.REG_WIDTH(16), .REG_ADDR_BITS(3)) bus1();

  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [7:0] fc0, fc1;
  logic [3:0] ff0, ff1, vi0, vi1;

  alu_test_sequencer #(
    .REG_WIDTH(16), .REG_ADDR_BITS(3), .NUM_VECTORS(16), .SETTLE_CYCLES(2)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .cpuBus(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .failCount(fc0),
    .firstFailIndex(ff0), .vectorIndex(vi0)
  );

  alu_test_sequencer #(
    .REG_WIDTH(16), .REG_ADDR_BITS(3), .NUM_VECTORS(1), .SETTLE_CYCLES(1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .cpuBus(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .failCount(fc1),
    .firstFailIndex(ff1), .vectorIndex(vi1)
  );

  // mode 0 correct ALU, 1 SUB with A=r2 returns 1, 2 result stuck at 0
  function automatic logic [15:0] aluModel(input logic [3:0] op, input logic [2:0] a,
                                           input logic [2:0] b, input int mode);
    logic [15:0] ra, rb, r;
    ra = {13'd0, a};
    rb = {13'd0, b};
    case (op)
      OP_ADD, OP_ADDU: r = ra + rb;
      OP_SUB:          r = ra - rb;
      OP_AND:          r = ra & rb;
      OP_OR:           r = ra | rb;
      OP_XOR:          r = ra ^ rb;
      default:         r = '0;
    endcase
    if (mode == 1 && op == OP_SUB && a == 3'd2) r = 16'h0001;
    if (mode == 2) r = '0;
    return r;
  endfunction

  always_comb bus0.aluResult = aluModel(bus0.aluOpCode, bus0.regAddressA, bus0.regAddressB, faultMode);
  always_comb bus1.aluResult = aluModel(bus1.aluOpCode, bus1.regAddressA, bus1.regAddressB, 0);

  typedef struct {
    string name;
    int    passV;
    int    fc;
    int    ff;
    int    vi;
    int    startCycle;
  } exp_t;

  exp_t sbq[$];
  exp_t monExp;
  logic prevDone0 = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic pushExp(input string name, input int p, input int fc, input int ff);
    exp_t x;
    x.name = name; x.passV = p; x.fc = fc; x.ff = ff; x.vi = 15; x.startCycle = cycleCount;
    sbq.push_back(x);
  endtask

  // Returns at the first negedge with done0 high, or reports a timeout.
  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (!done0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done0) begin
      total++;
      bad++;
      $display("FAIL %s.timeout: actual=no done required=done within 200 cycles", name);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, ".busy"}, busy0, 0);
    check({tag, ".done"}, done0, 0);
    check({tag, ".pass"}, pass0, 0);
    check({tag, ".failCount"}, fc0, 0);
    check({tag, ".firstFail"}, ff0, 15);
    check({tag, ".vectorIndex"}, vi0, 0);
    check({tag, ".opCode"}, bus0.aluOpCode, 0);
    check({tag, ".addrA"}, bus0.regAddressA, 0);
    check({tag, ".addrB"}, bus0.regAddressB, 0);
    check({tag, ".writeEnable"}, bus0.regWriteEnable, 0);
  endtask

  task automatic runOnce(input string name, input int mode, input int p, input int fc, input int ff);
    faultMode = mode;
    pushExp(name, p, fc, ff);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(name);
    @(negedge clk);
  endtask

  // Monitor: every rising done consumes one expected result.
  always @(negedge clk) begin
    if (done0 && !prevDone0) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpectedDone: actual=done rose required=no pending run");
      end else begin
        monExp = sbq.pop_front();
        check({monExp.name, ".pass"}, pass0, monExp.passV);
        check({monExp.name, ".failCount"}, fc0, monExp.fc);
        check({monExp.name, ".firstFail"}, ff0, monExp.ff);
        check({monExp.name, ".vectorIndex"}, vi0, monExp.vi);
        check({monExp.name, ".latency"}, cycleCount - monExp.startCycle, 65);
        check({monExp.name, ".writeEnable"}, bus0.regWriteEnable, 0);
      end
    end
    prevDone0 <= done0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sc;
    int n;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    check("reset.dut1.firstFail", ff1, 15);
    reset = 1'b0;
    @(negedge clk);

    runOnce("correct", 0, 1, 0, 15);
    runOnce("subFault", 1, 0, 1, 6);
    runOnce("stuckZero", 2, 0, 11, 1);

    // start held across a whole run: no retrigger while busy, restart on first DONE cycle
    faultMode = 0;
    pushExp("heldA", 1, 0, 15);
    start = 1'b1;
    @(negedge clk);
    waitDone("heldA");
    pushExp("heldB", 1, 0, 15);
    @(negedge clk);
    check("held.doneWidth", done0, 0);
    check("held.restartBusy", busy0, 1);
    check("held.restartIndex", vi0, 0);
    start = 1'b0;
    waitDone("heldB");
    @(negedge clk);

    // reset in the middle of vector 5's settle window
    faultMode = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vi0 != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midReset.reachedVector5", vi0, 5);
    check("midReset.preFails", fc0, 4);
    check("midReset.preFirstFail", ff0, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkIdle("midReset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("afterReset.idleBusy", busy0, 0);

    // single-vector instance: inputs stable from APPLY through CHECK, done 4 cycles after start
    sc = cycleCount;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("small.busy%0d", i), busy1, 1);
      check($sformatf("small.done%0d", i), done1, 0);
      check($sformatf("small.opCode%0d", i), bus1.aluOpCode, OP_ADD);
      check($sformatf("small.addrA%0d", i), bus1.regAddressA, 0);
      check($sformatf("small.addrB%0d", i), bus1.regAddressB, 0);
      @(negedge clk);
    end
    check("small.done", done1, 1);
    check("small.latency", cycleCount - sc, 4);
    check("small.pass", pass1, 1);
    check("small.failCount", fc1, 0);
    check("small.firstFail", ff1, 15);
    check("small.vectorIndex", vi1, 0);

    check("scoreboard.pending", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
